fetch_stage: RTL and testbench

Parametrised, pipelined instruction-fetch stage for the MIPS core, replacing the single-cycle fetch unit. It holds the PC, drives a combinational instruction ROM, and registers the fetched word into an IF/ID pipeline register. It accepts stall and redirect from the decode stage, where redirect means a taken branch or jump. It also computes branch and jump targets relative to the decode-stage PC.

---
 rtl/mips_pkg.sv | 19 +
 rtl/fetch_target_calc.sv | 27 ++
 rtl/fetch_stage.sv | 105 ++++++++++
 tb/tb_fetch_stage.sv | 228 ++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS core definitions: default widths, reset PC, NOP encoding and
// the per-cycle fetch action used by the fetch stage.
package mips_pkg;

    localparam int unsigned DEF_PC_W     = 30;
    localparam int unsigned DEF_IMEM_AW  = 8;
    localparam int unsigned DEF_INSTR_W  = 32;
    localparam int unsigned DEF_RESET_PC = 0;

    localparam logic [31:0] NOP = 32'h0;

    // What the fetch stage does on a non-reset edge.
    typedef enum logic [1:0] {
        ACT_HOLD,
        ACT_REDIRECT,
        ACT_SEQ
    } fetch_act_t;

endpackage

// File: rtl/fetch_target_calc.sv
// Combinational branch/jump target computation relative to the decode-stage
// sequential PC. Jump takes precedence over a taken branch.
module fetch_target_calc
    import mips_pkg::*;
#(
    parameter int unsigned PC_W = DEF_PC_W
) (
    input  logic [PC_W-1:0] pc_seq,
    input  logic [15:0]     imm16,
    input  logic [25:0]     addr26,
    input  logic            is_jump,
    output logic [PC_W-1:0] target
);

    logic [PC_W-1:0] imm_sext;
    logic [PC_W-1:0] br_tgt;
    logic [PC_W-1:0] jump_tgt;

    // Sign-extend the offset, form both targets and pick jump over branch.
    always_comb begin
        imm_sext = {{(PC_W-16){imm16[15]}}, imm16};
        br_tgt   = pc_seq + imm_sext;
        jump_tgt = {pc_seq[PC_W-1:26], addr26};
        target   = is_jump ? jump_tgt : br_tgt;
    end

endmodule

// File: rtl/fetch_stage.sv
// Pipelined instruction-fetch stage: PC register, ROM addressing and the
// IF/ID pipeline register with reset > stall > redirect > sequential priority.
// Optional macro FETCH_PERF_EN adds saturating perf_fetched / perf_bubbles
// counters and their output ports.
module fetch_stage
    import mips_pkg::*;
#(
    parameter int unsigned     PC_W     = DEF_PC_W,
    parameter int unsigned     IMEM_AW  = DEF_IMEM_AW,
    parameter int unsigned     INSTR_W  = DEF_INSTR_W,
    parameter logic [PC_W-1:0] RESET_PC = PC_W'(DEF_RESET_PC)
) (
    input  logic               clk,
    input  logic               rst_n,
    output logic [IMEM_AW-1:0] imem_addr,
    input  logic [INSTR_W-1:0] imem_data,
    input  logic               stall,
    input  logic               is_jump,
    input  logic               is_branch_taken,
    input  logic [15:0]        imm16,
    input  logic [25:0]        addr26,
    output logic [PC_W-1:0]    pc,
    output logic [INSTR_W-1:0] if_id_instr,
    output logic [PC_W-1:0]    if_id_pc_seq,
    output logic               if_id_valid
`ifdef FETCH_PERF_EN
    ,
    output logic [31:0]        perf_fetched,
    output logic [31:0]        perf_bubbles
`endif
);

    fetch_act_t      act;
    logic            redirect;
    logic [PC_W-1:0] target;
    logic [PC_W-1:0] pc_inc;

    fetch_target_calc #(
        .PC_W (PC_W)
    ) u_target (
        .pc_seq  (if_id_pc_seq),
        .imm16   (imm16),
        .addr26  (addr26),
        .is_jump (is_jump),
        .target  (target)
    );

    assign imem_addr = pc[IMEM_AW-1:0];
    assign pc_inc    = pc + PC_W'(1);

    // Select this cycle's action; a bubble in IF/ID can never redirect.
    always_comb begin
        act      = ACT_SEQ;
        redirect = if_id_valid & (is_jump | is_branch_taken);
        if (stall) begin
            act = ACT_HOLD;
        end else if (redirect) begin
            act = ACT_REDIRECT;
        end
    end

    // PC and IF/ID register update.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc           <= RESET_PC;
            if_id_instr  <= INSTR_W'(NOP);
            if_id_pc_seq <= '0;
            if_id_valid  <= 1'b0;
        end else begin
            unique case (act)
                ACT_HOLD: ;
                ACT_REDIRECT: begin
                    pc          <= target;
                    if_id_instr <= INSTR_W'(NOP);
                    if_id_valid <= 1'b0;
                end
                ACT_SEQ: begin
                    pc           <= pc_inc;
                    if_id_instr  <= imem_data;
                    if_id_pc_seq <= pc_inc;
                    if_id_valid  <= 1'b1;
                end
                default: ;
            endcase
        end
    end

`ifdef FETCH_PERF_EN
    // Saturating event counters; stall cycles are neither fetches nor bubbles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            perf_fetched <= '0;
            perf_bubbles <= '0;
        end else begin
            if (act == ACT_SEQ && perf_fetched != '1) begin
                perf_fetched <= perf_fetched + 32'd1;
            end
            if (act == ACT_REDIRECT && perf_bubbles != '1) begin
                perf_bubbles <= perf_bubbles + 32'd1;
            end
        end
    end
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, a hand-written
// perf/stall sequence, then randomized traffic against a behavioural model.
// Perf counter checks are compiled in when FETCH_PERF_EN is defined.
module tb_fetch_stage;

    localparam longint PC_MOD = 64'h4000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  imem_addr;
    logic [31:0] imem_data;
    logic        stall;
    logic        is_jump;
    logic        is_branch_taken;
    logic [15:0] imm16;
    logic [25:0] addr26;
    logic [29:0] pc;
    logic [31:0] if_id_instr;
    logic [29:0] if_id_pc_seq;
    logic        if_id_valid;
`ifdef FETCH_PERF_EN
    logic [31:0] perf_fetched;
    logic [31:0] perf_bubbles;
`endif

    logic [31:0] rom [256];

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    assign imem_data = rom[imem_addr];

    fetch_stage #(
        .PC_W     (30),
        .IMEM_AW  (8),
        .INSTR_W  (32),
        .RESET_PC (30'd0)
    ) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .imem_addr       (imem_addr),
        .imem_data       (imem_data),
        .stall           (stall),
        .is_jump         (is_jump),
        .is_branch_taken (is_branch_taken),
        .imm16           (imm16),
        .addr26          (addr26),
        .pc              (pc),
        .if_id_instr     (if_id_instr),
        .if_id_pc_seq    (if_id_pc_seq),
        .if_id_valid     (if_id_valid)
`ifdef FETCH_PERF_EN
        ,
        .perf_fetched    (perf_fetched),
        .perf_bubbles    (perf_bubbles)
`endif
    );

    typedef struct {
        bit          rst_n;
        bit          stall;
        bit          jump;
        bit          br;
        logic [15:0] imm;
        logic [25:0] a26;
        longint      pc;
        longint      instr;
        longint      seq;
        bit          valid;
    } vec_t;

    function automatic vec_t mk(bit r, bit s, bit j, bit b, logic [15:0] imm,
                                logic [25:0] a26, longint p, longint i,
                                longint q, bit v);
        vec_t t;
        t.rst_n = r; t.stall = s; t.jump = j; t.br = b; t.imm = imm; t.a26 = a26;
        t.pc = p; t.instr = i; t.seq = q; t.valid = v;
        return t;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            n_pass++;
        end
    endtask

    task automatic drive(input bit r, input bit s, input bit j, input bit b,
                         input logic [15:0] imm, input logic [25:0] a26);
        rst_n = r; stall = s; is_jump = j; is_branch_taken = b;
        imm16 = imm; addr26 = a26;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_state(input string tag, input longint p, input longint i,
                               input longint q, input bit v);
        check({tag, ".pc"}, 64'(pc), p);
        check({tag, ".imem_addr"}, 64'(imem_addr), p % 256);
        check({tag, ".instr"}, 64'(if_id_instr), i);
        check({tag, ".pc_seq"}, 64'(if_id_pc_seq), q);
        check({tag, ".valid"}, 64'(if_id_valid), 64'(v));
    endtask

    // Behavioural reference state for the random phase.
    longint m_pc, m_instr, m_seq;
    bit     m_valid;
    longint m_fetched, m_bubbles;

    task automatic model_edge(input bit r, input bit s, input bit j, input bit b,
                              input logic [15:0] imm, input logic [25:0] a26);
        longint off;
        if (!r) begin
            m_pc = 0; m_instr = 0; m_seq = 0; m_valid = 0;
            m_fetched = 0; m_bubbles = 0;
        end else if (s) begin
            // frozen
        end else if (m_valid && (j || b)) begin
            off = longint'($signed(imm));
            if (j) m_pc = (m_seq / 64'h400_0000) * 64'h400_0000 + longint'(a26);
            else   m_pc = (((m_seq + off) % PC_MOD) + PC_MOD) % PC_MOD;
            m_instr = 0;
            m_valid = 0;
            m_bubbles++;
        end else begin
            m_instr = longint'(rom[m_pc % 256]);
            m_pc    = (m_pc + 1) % PC_MOD;
            m_seq   = m_pc;
            m_valid = 1;
            m_fetched++;
        end
    endtask

    vec_t vecs[26];

    initial begin
        for (int k = 0; k < 256; k++) rom[k] = 32'(k + 100);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);

        //               rst st  j  b  imm       a26        pc             instr seq            v
        vecs[0]  = mk(0, 0, 0, 0, 16'h0000, 26'h0,  0,             0,   0,             0);
        vecs[1]  = mk(0, 0, 0, 0, 16'h0000, 26'h0,  0,             0,   0,             0);
        vecs[2]  = mk(1, 0, 0, 0, 16'h0000, 26'h0,  1,             100, 1,             1);
        vecs[3]  = mk(1, 0, 0, 0, 16'h0000, 26'h0,  2,             101, 2,             1);
        vecs[4]  = mk(1, 0, 0, 0, 16'h0000, 26'h0,  3,             102, 3,             1);
        vecs[5]  = mk(1, 0, 0, 0, 16'h0000, 26'h0,  4,             103, 4,             1);
        vecs[6]  = mk(1, 0, 0, 0, 16'h0000, 26'h0,  5,             104, 5,             1);
        vecs[7]  = mk(1, 0, 0, 1, 16'hFFFE, 26'h0,  3,             0,   5,             0);
        vecs[8]  = mk(1, 0, 1, 0, 16'h0000, 26'h50, 4,             103, 4,             1);
        vecs[9]  = mk(1, 0, 1, 1, 16'hFFFE, 26'h20, 32,            0,   4,             0);
        vecs[10] = mk(1, 0, 0, 0, 16'h0000, 26'h0,  33,            132, 33,            1);
        vecs[11] = mk(1, 0, 0, 1, 16'hFFE5, 26'h0,  6,             0,   33,            0);
        vecs[12] = mk(1, 0, 0, 0, 16'h0000, 26'h0,  7,             106, 7,             1);
        vecs[13] = mk(1, 1, 1, 1, 16'h0004, 26'h10, 7,             106, 7,             1);
        vecs[14] = mk(1, 1, 1, 1, 16'h0004, 26'h10, 7,             106, 7,             1);
        vecs[15] = mk(1, 1, 1, 1, 16'h0004, 26'h10, 7,             106, 7,             1);
        vecs[16] = mk(1, 0, 0, 0, 16'h0004, 26'h10, 8,             107, 8,             1);
        vecs[17] = mk(1, 0, 1, 0, 16'h0004, 26'h10, 16,            0,   8,             0);
        vecs[18] = mk(1, 0, 0, 0, 16'h0000, 26'h0,  17,            116, 17,            1);
        vecs[19] = mk(1, 0, 0, 1, 16'hFFED, 26'h0,  64'h3FFFFFFE,  0,   17,            0);
        vecs[20] = mk(1, 0, 0, 0, 16'h0000, 26'h0,  64'h3FFFFFFF,  354, 64'h3FFFFFFF,  1);
        vecs[21] = mk(1, 0, 0, 0, 16'h0000, 26'h0,  0,             355, 0,             1);
        vecs[22] = mk(1, 0, 0, 0, 16'h0000, 26'h0,  1,             100, 1,             1);
        vecs[23] = mk(0, 0, 1, 0, 16'h0000, 26'h7,  0,             0,   0,             0);
        vecs[24] = mk(0, 1, 0, 0, 16'h0000, 26'h0,  0,             0,   0,             0);
        vecs[25] = mk(1, 0, 0, 0, 16'h0000, 26'h0,  1,             100, 1,             1);

        for (int v = 0; v < 26; v++) begin
            drive(vecs[v].rst_n, vecs[v].stall, vecs[v].jump, vecs[v].br,
                  vecs[v].imm, vecs[v].a26);
            step();
            check_state($sformatf("vec%0d", v), vecs[v].pc, vecs[v].instr,
                        vecs[v].seq, vecs[v].valid);
        end

        // Counters: 3 fetches, 1 redirect, 2 stalled cycles with redirect pending.
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0); step();
        drive(1'b1, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        step(); step(); step();
        check_state("perf_seq", 3, 102, 3, 1'b1);
        drive(1'b1, 1'b0, 1'b0, 1'b1, 16'h0000, 26'h0); step();
        check_state("perf_redir", 3, 0, 3, 1'b0);
        drive(1'b1, 1'b1, 1'b1, 1'b0, 16'h0, 26'h9); step(); step();
        check_state("perf_stall", 3, 0, 3, 1'b0);
`ifdef FETCH_PERF_EN
        check("perf_fetched", 64'(perf_fetched), 3);
        check("perf_bubbles", 64'(perf_bubbles), 1);
`endif
        drive(1'b1, 1'b0, 1'b1, 1'b0, 16'h0, 26'h9); step();
        check_state("perf_release", 4, 103, 4, 1'b1);

        // Randomized traffic against the reference model.
        for (int k = 0; k < 256; k++) rom[k] = $urandom;
        drive(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        model_edge(1'b0, 1'b0, 1'b0, 1'b0, 16'h0, 26'h0);
        step();
        for (int c = 0; c < 2000; c++) begin
            bit          r, s, j, b;
            logic [15:0] imm;
            logic [25:0] a26;
            r   = ($urandom_range(0, 39) != 0);
            s   = ($urandom_range(0, 3) == 0);
            j   = ($urandom_range(0, 4) == 0);
            b   = ($urandom_range(0, 3) == 0);
            imm = 16'($urandom);
            a26 = 26'($urandom);
            drive(r, s, j, b, imm, a26);
            model_edge(r, s, j, b, imm, a26);
            step();
            check_state($sformatf("rnd%0d", c), m_pc, m_instr, m_seq, m_valid);
`ifdef FETCH_PERF_EN
            check("rnd.perf_fetched", 64'(perf_fetched), m_fetched);
            check("rnd.perf_bubbles", 64'(perf_bubbles), m_bubbles);
`endif
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
